// File: rtl/scenario_loader_pkg.sv
// Shared constants, FSM state type and frame-geometry helper for the scenario loader.
package scenario_loader_pkg;

  localparam logic [7:0] FRAME_SYNC = 8'hA5;

  typedef enum logic [1:0] {StHunt, StPayload, StCheck, StCommit} loader_state_t;

  // Record length: D locations + D velocities (WIDTH/8 bytes each), mass (WIDTH/16), radius (1).
  function automatic int unsigned bytes_per_sprite(int unsigned width, int unsigned dimensions);
    return 4 * dimensions * width / 16 + width / 16 + 1;
  endfunction

endpackage

// File: rtl/scenario_loader_if.sv
// Byte-stream valid/ready link from the host receiver into the scenario loader.
interface scenario_loader_if;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;

  modport master (output in_valid, output in_data, input in_ready);
  modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/scenario_loader_field_demux.sv
// Tracks the payload position as (sprite, byte-in-record) and decodes which staging
// field the current byte belongs to.
module scenario_loader_field_demux
  import scenario_loader_pkg::*;
#(
  parameter int unsigned SPRITES    = 9,
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned DIMENSIONS = 2,
  localparam int unsigned SprW      = (SPRITES > 1) ? $clog2(SPRITES) : 1
) (
  input  logic                  clk_162,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  advance,
  output logic [SprW-1:0]       sprite,
  output logic [DIMENSIONS-1:0] loc_we,
  output logic [DIMENSIONS-1:0] velo_we,
  output logic                  mass_we,
  output logic                  radius_we,
  output logic                  last
);

  localparam int unsigned Bps       = bytes_per_sprite(WIDTH, DIMENSIONS);
  localparam int unsigned OffW      = $clog2(Bps);
  localparam int unsigned LocBytes  = WIDTH / 8;
  localparam int unsigned MassOff   = 2 * DIMENSIONS * LocBytes;
  localparam int unsigned MassBytes = WIDTH / 16;
  localparam int unsigned RadiusOff = MassOff + MassBytes;

  logic [SprW-1:0] sprite_q;
  logic [OffW-1:0] offset_q;
  logic            rec_end;
  int unsigned     off;
  int unsigned     spr;

  // Range tests use unsigned wrap: (off - base) < len is false whenever off < base.
  always_comb begin
    off       = 32'(offset_q);
    spr       = 32'(sprite_q);
    rec_end   = (off == Bps - 1);
    last      = rec_end && (spr == SPRITES - 1);
    loc_we    = '0;
    velo_we   = '0;
    for (int unsigned d = 0; d < DIMENSIONS; d++) begin
      loc_we[d]  = (off - d * LocBytes) < LocBytes;
      velo_we[d] = (off - (DIMENSIONS + d) * LocBytes) < LocBytes;
    end
    mass_we   = (off - MassOff) < MassBytes;
    radius_we = (off == RadiusOff);
  end

  always_ff @(posedge clk_162) begin
    if (rst || clear) begin
      sprite_q <= '0;
      offset_q <= '0;
    end else if (advance) begin
      if (rec_end) begin
        offset_q <= '0;
        sprite_q <= last ? '0 : sprite_q + 1'b1;
      end else begin
        offset_q <= offset_q + 1'b1;
      end
    end
  end

  assign sprite = sprite_q;

endmodule

// File: rtl/scenario_loader.sv
// Receives sync/payload/checksum scenario frames, stages them, and commits a frame atomically
// to the physics-engine outputs only when its XOR checksum matches.
module scenario_loader
  import scenario_loader_pkg::*;
#(
  parameter int unsigned SPRITES    = 9,
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned DIMENSIONS = 2,
  parameter int unsigned TIMEOUT    = 16200
) (
  input  logic                                clk_162,
  input  logic                                rst,
  scenario_loader_if.slave                    host,
  output logic [SPRITES*DIMENSIONS*WIDTH-1:0] init_locations,
  output logic [SPRITES*DIMENSIONS*WIDTH-1:0] init_velos,
  output logic [SPRITES*WIDTH/2-1:0]          masses,
  output logic [SPRITES*7-1:0]                radii,
  output logic                                data_ready,
  output logic                                frame_error
);

  localparam int unsigned SprW  = (SPRITES > 1) ? $clog2(SPRITES) : 1;
  localparam int unsigned MassW = WIDTH / 2;
  localparam int unsigned IdleW = $clog2(TIMEOUT + 1);

  typedef logic [SPRITES-1:0][DIMENSIONS-1:0][WIDTH-1:0] vec_arr_t;

  loader_state_t                  state_q, state_d;
  logic [7:0]                     xor_q, xor_d;
  logic [IdleW-1:0]               idle_q, idle_d;
  logic                           accept, pay_we, frame_start, commit, err_d;

  vec_arr_t                       stage_loc_q, stage_velo_q, loc_q, velo_q;
  logic [SPRITES-1:0][MassW-1:0]  stage_mass_q, mass_q;
  logic [SPRITES-1:0][6:0]        stage_radius_q, radius_q;

  logic [SprW-1:0]                sprite;
  logic [DIMENSIONS-1:0]          loc_we, velo_we;
  logic                           mass_we, radius_we, last;

  assign host.in_ready = (state_q != StCommit);
  assign accept        = host.in_valid && host.in_ready;

  scenario_loader_field_demux #(
    .SPRITES    (SPRITES),
    .WIDTH      (WIDTH),
    .DIMENSIONS (DIMENSIONS)
  ) u_demux (
    .clk_162   (clk_162),
    .rst       (rst),
    .clear     (frame_start),
    .advance   (pay_we),
    .sprite    (sprite),
    .loc_we    (loc_we),
    .velo_we   (velo_we),
    .mass_we   (mass_we),
    .radius_we (radius_we),
    .last      (last)
  );

  always_comb begin
    state_d     = state_q;
    xor_d       = xor_q;
    idle_d      = idle_q;
    err_d       = 1'b0;
    commit      = 1'b0;
    frame_start = 1'b0;
    pay_we      = 1'b0;
    unique case (state_q)
      StHunt: begin
        idle_d = '0;
        if (accept && host.in_data == FRAME_SYNC) begin
          state_d     = StPayload;
          xor_d       = '0;
          frame_start = 1'b1;
        end
      end
      StPayload, StCheck: begin
        if (accept) begin
          idle_d = '0;
          if (state_q == StPayload) begin
            pay_we = 1'b1;
            xor_d  = xor_q ^ host.in_data;
            if (last) state_d = StCheck;
          end else if (host.in_data == xor_q) begin
            state_d = StCommit;
          end else begin
            err_d   = 1'b1;
            state_d = StHunt;
          end
        end else if (idle_q == IdleW'(TIMEOUT - 1)) begin
          // This idle cycle is the TIMEOUT-th one in a row; abandon the frame.
          err_d   = 1'b1;
          state_d = StHunt;
          idle_d  = '0;
        end else begin
          idle_d = idle_q + 1'b1;
        end
      end
      StCommit: begin
        commit  = 1'b1;
        state_d = StHunt;
      end
      default: state_d = StHunt;
    endcase
  end

  always_ff @(posedge clk_162) begin
    if (rst) begin
      state_q     <= StHunt;
      xor_q       <= '0;
      idle_q      <= '0;
      data_ready  <= 1'b0;
      frame_error <= 1'b0;
      loc_q       <= '0;
      velo_q      <= '0;
      mass_q      <= '0;
      radius_q    <= '0;
    end else begin
      state_q     <= state_d;
      xor_q       <= xor_d;
      idle_q      <= idle_d;
      data_ready  <= commit;
      frame_error <= err_d;
      if (commit) begin
        loc_q    <= stage_loc_q;
        velo_q   <= stage_velo_q;
        mass_q   <= stage_mass_q;
        radius_q <= stage_radius_q;
      end
    end
  end

  // Every field byte is shifted in MSB first, so a complete record fully overwrites its slot.
  always_ff @(posedge clk_162) begin
    if (rst) begin
      stage_loc_q    <= '0;
      stage_velo_q   <= '0;
      stage_mass_q   <= '0;
      stage_radius_q <= '0;
    end else if (pay_we) begin
      for (int unsigned d = 0; d < DIMENSIONS; d++) begin
        if (loc_we[d]) begin
          stage_loc_q[sprite][d] <= {stage_loc_q[sprite][d][WIDTH-9:0], host.in_data};
        end
        if (velo_we[d]) begin
          stage_velo_q[sprite][d] <= {stage_velo_q[sprite][d][WIDTH-9:0], host.in_data};
        end
      end
      if (mass_we) begin
        stage_mass_q[sprite] <= {stage_mass_q[sprite][MassW-9:0], host.in_data};
      end
      if (radius_we) begin
        stage_radius_q[sprite] <= host.in_data[6:0];
      end
    end
  end

  assign init_locations = loc_q;
  assign init_velos     = velo_q;
  assign masses         = mass_q;
  assign radii          = radius_q;

endmodule

// File: tb/tb_scenario_loader.sv
// Scoreboard bench: the driver queues the expected strobe and committed image per frame, a
// negedge monitor pops and compares whenever data_ready or frame_error fires.
module tb_scenario_loader;
  import scenario_loader_pkg::*;

  localparam int unsigned S  = 9;
  localparam int unsigned D  = 2;
  localparam int unsigned W  = 32;
  localparam int unsigned T  = 16200;
  localparam int unsigned LW = S * D * W;
  localparam int unsigned MW = S * W / 2;
  localparam int unsigned RW = S * 7;

  typedef struct {
    bit                is_err;
    longint unsigned   at;
    logic [LW-1:0]     loc;
    logic [LW-1:0]     velo;
    logic [MW-1:0]     mass;
    logic [RW-1:0]     rad;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [LW-1:0] init_locations, init_velos;
  logic [MW-1:0] masses;
  logic [RW-1:0] radii;
  logic          data_ready, frame_error;

  scenario_loader_if host ();

  scenario_loader #(
    .SPRITES    (S),
    .WIDTH      (W),
    .DIMENSIONS (D),
    .TIMEOUT    (T)
  ) dut (
    .clk_162        (clk),
    .rst            (rst),
    .host           (host),
    .init_locations (init_locations),
    .init_velos     (init_velos),
    .masses         (masses),
    .radii          (radii),
    .data_ready     (data_ready),
    .frame_error    (frame_error)
  );

  always #5 clk = ~clk;

  int              checks  = 0;
  int              errors  = 0;
  int              commits = 0;
  int              low_cnt = 0;
  bit              mon_en  = 1'b0;
  bit              prev_low = 1'b0;
  longint unsigned last_accept = 0;
  exp_t            sb[$];
  exp_t            mon_e;

  logic [W-1:0]  f_loc [S][D];
  logic [W-1:0]  f_velo[S][D];
  logic [15:0]   f_mass[S];
  logic [7:0]    f_rad [S];
  logic [LW-1:0] m_loc, m_velo;
  logic [MW-1:0] m_mass;
  logic [RW-1:0] m_rad;

  task automatic check_vec(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic clear_frame();
    for (int s = 0; s < S; s++) begin
      for (int d = 0; d < D; d++) begin
        f_loc[s][d]  = '0;
        f_velo[s][d] = '0;
      end
      f_mass[s] = '0;
      f_rad[s]  = '0;
    end
  endtask

  task automatic random_frame();
    for (int s = 0; s < S; s++) begin
      for (int d = 0; d < D; d++) begin
        f_loc[s][d]  = $urandom;
        f_velo[s][d] = $urandom;
      end
      f_mass[s] = 16'($urandom);
      f_rad[s]  = 8'($urandom);
    end
  endtask

  // Called right after a posedge (+1); a gap idles in_valid for that many cycles first.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int guard = 0;
    if (gap > 0) begin
      repeat (gap) @(posedge clk);
      #1;
    end
    host.in_valid = 1'b1;
    host.in_data  = b;
    @(negedge clk);
    while (host.in_ready !== 1'b1 && guard < 8) begin
      @(negedge clk);
      guard++;
    end
    if (host.in_ready !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL in_ready_stuck: got %b expected 1", host.in_ready);
    end
    @(posedge clk);
    last_accept = $time;
    #1;
    host.in_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] flip, input int max_gap, input int long_at);
    logic [7:0] pl[$];
    logic [7:0] x;
    exp_t       e;
    int         g;
    x = 8'h00;
    for (int s = 0; s < S; s++) begin
      for (int d = 0; d < D; d++)
        for (int k = W / 8 - 1; k >= 0; k--) pl.push_back(f_loc[s][d][k*8 +: 8]);
      for (int d = 0; d < D; d++)
        for (int k = W / 8 - 1; k >= 0; k--) pl.push_back(f_velo[s][d][k*8 +: 8]);
      pl.push_back(f_mass[s][15:8]);
      pl.push_back(f_mass[s][7:0]);
      pl.push_back(f_rad[s]);
    end
    send_byte(FRAME_SYNC, 0);
    foreach (pl[i]) begin
      x ^= pl[i];
      g = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
      if (i == long_at) g = T - 1;
      send_byte(pl[i], g);
    end
    send_byte(x ^ flip, 0);
    if (flip == 8'h00) begin
      for (int s = 0; s < S; s++) begin
        for (int d = 0; d < D; d++) begin
          m_loc[(s*D+d)*W +: W]  = f_loc[s][d];
          m_velo[(s*D+d)*W +: W] = f_velo[s][d];
        end
        m_mass[s*16 +: 16] = f_mass[s];
        m_rad[s*7 +: 7]    = f_rad[s][6:0];
      end
      commits++;
      e.is_err = 1'b0;
      e.at     = last_accept + 15;
    end else begin
      e.is_err = 1'b1;
      e.at     = last_accept + 5;
    end
    e.loc  = m_loc;
    e.velo = m_velo;
    e.mass = m_mass;
    e.rad  = m_rad;
    sb.push_back(e);
  endtask

  task automatic check_all_zero(input string tag);
    check_vec({tag, "_loc"}, init_locations, '0);
    check_vec({tag, "_velo"}, init_velos, '0);
    check_vec({tag, "_mass"}, LW'(masses), '0);
    check_vec({tag, "_radii"}, LW'(radii), '0);
    check_int({tag, "_in_ready"}, 64'(host.in_ready), 64'd1);
    check_int({tag, "_data_ready"}, 64'(data_ready), 64'd0);
    check_int({tag, "_frame_error"}, 64'(frame_error), 64'd0);
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (data_ready === 1'b1 && frame_error === 1'b1) begin
        checks++;
        errors++;
        $display("FAIL strobe_overlap: got both strobes expected at most one");
      end
      if (data_ready === 1'b1 || frame_error === 1'b1) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_strobe: got data_ready=%b frame_error=%b expected none",
                   data_ready, frame_error);
        end else begin
          mon_e = sb.pop_front();
          check_int("strobe_kind", 64'(frame_error), 64'(mon_e.is_err));
          check_int("strobe_time", 64'($time), mon_e.at);
          if (!mon_e.is_err) check_int("ready_low_before_commit", 64'(prev_low), 64'd1);
          check_vec("sb_locations", init_locations, mon_e.loc);
          check_vec("sb_velos", init_velos, mon_e.velo);
          check_vec("sb_masses", LW'(masses), LW'(mon_e.mass));
          check_vec("sb_radii", LW'(radii), LW'(mon_e.rad));
        end
      end
      if (host.in_ready === 1'b0) low_cnt++;
      prev_low = (host.in_ready === 1'b0);
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    host.in_valid = 1'b0;
    host.in_data  = 8'h00;
    m_loc = '0;
    m_velo = '0;
    m_mass = '0;
    m_rad = '0;
    clear_frame();

    // Reset held three cycles.
    repeat (3) @(posedge clk);
    #1;
    rst    = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);
    check_all_zero("reset");
    @(posedge clk);
    #1;

    // Single-sprite frame with hand-computed field placement.
    f_loc[0][0] = 32'h0001_0000;
    f_loc[0][1] = 32'hFFFF_0000;
    f_velo[0][0] = 32'h0000_0100;
    f_mass[0] = 16'h0040;
    f_rad[0] = 8'h0A;
    send_frame(8'h00, 0, -1);
    repeat (6) @(posedge clk);
    #1;
    check_vec("t2_loc", init_locations, LW'({32'hFFFF_0000, 32'h0001_0000}));
    check_vec("t2_velo", init_velos, LW'(32'h0000_0100));
    check_vec("t2_mass", LW'(masses), LW'(16'h0040));
    check_vec("t2_radii", LW'(radii), LW'(7'h0A));

    // Corrupted checksum on altered data: must not reach the outputs.
    f_rad[0] = 8'h0B;
    send_frame(8'h01, 0, -1);
    repeat (6) @(posedge clk);
    #1;
    check_vec("t3_radii_kept", LW'(radii), LW'(7'h0A));
    f_rad[0] = 8'h0A;

    // Junk before sync, 0xA5 inside the payload, radius bit 7 set.
    send_byte(8'h00, 0);
    send_byte(8'hFF, 0);
    send_byte(8'h5A, 0);
    f_loc[1][0] = 32'hA5A5_0001;
    f_velo[8][1] = 32'h0000_00A5;
    f_mass[4] = 16'hA500;
    f_rad[8] = 8'hA5;
    send_frame(8'h00, 0, -1);
    repeat (6) @(posedge clk);
    #1;
    check_vec("t4_radius8", LW'(radii[62:56]), LW'(7'h25));
    check_vec("t4_mass4", LW'(masses[79:64]), LW'(16'hA500));
    check_vec("t4_loc1_0", LW'(init_locations[95:64]), LW'(32'hA5A5_0001));

    // Stall mid-payload until the idle limit fires.
    send_byte(FRAME_SYNC, 0);
    for (int i = 0; i < 50; i++) send_byte(8'(i + 3), 0);
    begin
      exp_t e;
      e.is_err = 1'b1;
      e.at     = last_accept + T * 10 + 5;
      e.loc    = m_loc;
      e.velo   = m_velo;
      e.mass   = m_mass;
      e.rad    = m_rad;
      sb.push_back(e);
    end
    repeat (T + 5) @(posedge clk);
    #1;
    f_mass[2] = 16'h1234;
    send_frame(8'h00, 0, -1);
    repeat (6) @(posedge clk);
    #1;
    check_vec("t5_mass2", LW'(masses[47:32]), LW'(16'h1234));

    // Back-to-back frames with random gaps; one gap sits one cycle under the idle limit.
    random_frame();
    send_frame(8'h00, 3, 100);
    random_frame();
    send_frame(8'h00, 3, -1);
    random_frame();
    send_frame(8'h00, 0, -1);
    repeat (6) @(posedge clk);
    #1;

    // Reset in the middle of a frame drops it and clears committed outputs.
    send_byte(FRAME_SYNC, 0);
    for (int i = 0; i < 20; i++) send_byte(8'(i + 1), 0);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    m_loc = '0;
    m_velo = '0;
    m_mass = '0;
    m_rad = '0;
    @(negedge clk);
    check_all_zero("midreset");
    @(posedge clk);
    #1;
    send_frame(8'h00, 1, -1);

    repeat (10) @(posedge clk);
    #1;
    check_int("scoreboard_drained", 64'(sb.size()), 64'd0);
    check_int("ready_low_cycles", 64'(low_cnt), 64'(commits));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
